// File: rtl/disp_pkg.sv
// Shared types, owner codes and the 7-segment pattern table for the HEX display arbiter.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

   localparam logic [1:0] OWN_NONE  = 2'b00;
   localparam logic [1:0] OWN_A     = 2'b01;
   localparam logic [1:0] OWN_B     = 2'b10;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] seg7(input logic [3:0] hex);
      logic [6:0] pat;
      case (hex)
         4'h0:    pat = 7'h40;
         4'h1:    pat = 7'h79;
         4'h2:    pat = 7'h24;
         4'h3:    pat = 7'h30;
         4'h4:    pat = 7'h19;
         4'h5:    pat = 7'h12;
         4'h6:    pat = 7'h02;
         4'h7:    pat = 7'h78;
         4'h8:    pat = 7'h00;
         4'h9:    pat = 7'h10;
         4'hA:    pat = 7'h08;
         4'hB:    pat = 7'h03;
         4'hC:    pat = 7'h46;
         4'hD:    pat = 7'h21;
         4'hE:    pat = 7'h06;
         default: pat = 7'h0E;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg7_dec.sv
// One hex nibble to one active-low 7-segment digit; purely combinational.
module seg7_dec
   import disp_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = seg7(hex);

endmodule

// File: rtl/hex_disp_arbiter.sv
// Round-robin arbiter sharing the six HEX digits between two requesters, each grant held HOLD_CYCLES clocks.
// Build option: define DISP_LZ_BLANK_EN to blank leading zero digits (HEX0 always shown).
module hex_disp_arbiter
   import disp_pkg::*;
#(
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int DIGITS      = 6
)
(
   input  logic                  CLOCK_50,
   input  logic                  RESET_N,
   input  logic                  req_a,
   input  logic [4*DIGITS-1:0]   data_a,
   output logic                  ack_a,
   input  logic                  req_b,
   input  logic [4*DIGITS-1:0]   data_b,
   output logic                  ack_b,
   output logic [1:0]            owner,
   output logic [6:0]            HEX5,
   output logic [6:0]            HEX4,
   output logic [6:0]            HEX3,
   output logic [6:0]            HEX2,
   output logic [6:0]            HEX1,
   output logic [6:0]            HEX0
);

   // A one-cycle hold still needs a 1-bit counter, which simply stays at zero.
   localparam int              CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t                state_reg, state_next;
   req_id_t               last_reg;
   logic [CNT_W-1:0]      hold_cnt_reg;
   logic [4*DIGITS-1:0]   disp_reg;
   logic                  shown_reg;
   logic                  ack_a_reg, ack_b_reg;
   logic                  grant_a, grant_b;
   logic                  expired;
   logic [6:0]            seg_out [6];

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg    <= IDLE;
         last_reg     <= REQ_B;
         hold_cnt_reg <= '0;
         disp_reg     <= '0;
         shown_reg    <= 1'b0;
         ack_a_reg    <= 1'b0;
         ack_b_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         ack_a_reg <= grant_a;
         ack_b_reg <= grant_b;
         if (grant_a) begin
            disp_reg     <= data_a;
            shown_reg    <= 1'b1;
            last_reg     <= REQ_A;
            hold_cnt_reg <= HOLD_LAST;
         end else if (grant_b) begin
            disp_reg     <= data_b;
            shown_reg    <= 1'b1;
            last_reg     <= REQ_B;
            hold_cnt_reg <= HOLD_LAST;
         end else if (state_reg != IDLE && !expired) begin
            hold_cnt_reg <= hold_cnt_reg - CNT_W'(1);
         end
      end
   end

   // At expiry the other side is served first, so a waiting requester never starves.
   always_comb begin
      state_next = state_reg;
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      expired    = (hold_cnt_reg == '0);
      case (state_reg)
         IDLE: begin
            if (req_a && req_b) begin
               if (last_reg == REQ_B) grant_a = 1'b1;
               else                   grant_b = 1'b1;
            end else if (req_a) begin
               grant_a = 1'b1;
            end else if (req_b) begin
               grant_b = 1'b1;
            end
         end
         GNT_A: begin
            if (expired) begin
               if      (req_b) grant_b    = 1'b1;
               else if (req_a) grant_a    = 1'b1;
               else            state_next = IDLE;
            end
         end
         GNT_B: begin
            if (expired) begin
               if      (req_a) grant_a    = 1'b1;
               else if (req_b) grant_b    = 1'b1;
               else            state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (grant_a)      state_next = GNT_A;
      else if (grant_b) state_next = GNT_B;
   end

   assign ack_a = ack_a_reg;
   assign ack_b = ack_b_reg;
   assign owner = (state_reg == GNT_A) ? OWN_A :
                  (state_reg == GNT_B) ? OWN_B : OWN_NONE;

`ifdef DISP_LZ_BLANK_EN
   // lz[i] is set when digit i and every digit above it are zero.
   logic [DIGITS:1] lz;
   assign lz[DIGITS] = 1'b1;
   for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign lz[gi] = lz[gi+1] && (disp_reg[4*gi +: 4] == 4'h0);
   end
`endif

   for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      if (gi < DIGITS) begin : g_on
         logic [6:0] seg_raw;
         logic       blank;
         seg7_dec u_dec (
            .hex (disp_reg[4*gi +: 4]),
            .seg (seg_raw)
         );
`ifdef DISP_LZ_BLANK_EN
         if (gi == 0) begin : g_lsd
            assign blank = 1'b0;
         end else begin : g_upper
            assign blank = lz[gi];
         end
`else
         assign blank = 1'b0;
`endif
         assign seg_out[gi] = (!shown_reg || blank) ? SEG_BLANK : seg_raw;
      end else begin : g_off
         assign seg_out[gi] = SEG_BLANK;
      end
   end

   assign HEX0 = seg_out[0];
   assign HEX1 = seg_out[1];
   assign HEX2 = seg_out[2];
   assign HEX3 = seg_out[3];
   assign HEX4 = seg_out[4];
   assign HEX5 = seg_out[5];

endmodule

// File: tb/tb_hex_disp_arbiter.sv
// Directed bench for hex_disp_arbiter with HOLD_CYCLES=4; expected segment codes are hand-computed.
module tb_hex_disp_arbiter;
   import disp_pkg::*;

   localparam int HOLD = 4;
`ifdef DISP_LZ_BLANK_EN
   localparam logic [6:0] HEX5_ZERO = 7'h7F;
`else
   localparam logic [6:0] HEX5_ZERO = 7'h40;
`endif

   logic        CLOCK_50 = 1'b0;
   logic        RESET_N  = 1'b0;
   logic        req_a    = 1'b0;
   logic        req_b    = 1'b0;
   logic [23:0] data_a   = '0;
   logic [23:0] data_b   = '0;
   logic        ack_a, ack_b;
   logic [1:0]  owner;
   logic [6:0]  HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

   int total = 0;
   int bad   = 0;

   hex_disp_arbiter #(.HOLD_CYCLES(HOLD), .DIGITS(6)) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .req_a    (req_a),
      .data_a   (data_a),
      .ack_a    (ack_a),
      .req_b    (req_b),
      .data_b   (data_b),
      .ack_b    (ack_b),
      .owner    (owner),
      .HEX5     (HEX5),
      .HEX4     (HEX4),
      .HEX3     (HEX3),
      .HEX2     (HEX2),
      .HEX1     (HEX1),
      .HEX0     (HEX0)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check_hex(input string tag,
                            input logic [6:0] e5, input logic [6:0] e4, input logic [6:0] e3,
                            input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
      check({tag, ".hex5"}, 32'(HEX5), 32'(e5));
      check({tag, ".hex4"}, 32'(HEX4), 32'(e4));
      check({tag, ".hex3"}, 32'(HEX3), 32'(e3));
      check({tag, ".hex2"}, 32'(HEX2), 32'(e2));
      check({tag, ".hex1"}, 32'(HEX1), 32'(e1));
      check({tag, ".hex0"}, 32'(HEX0), 32'(e0));
   endtask

   task automatic check_ctl(input string tag, input logic ea, input logic eb, input logic [1:0] eo);
      check({tag, ".ack_a"}, 32'(ack_a), 32'(ea));
      check({tag, ".ack_b"}, 32'(ack_b), 32'(eb));
      check({tag, ".owner"}, 32'(owner), 32'(eo));
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      req_a   = 1'b0;
      req_b   = 1'b0;
      repeat (2) tick();
      RESET_N = 1'b1;
      tick();
   endtask

   initial begin
      // 1: reset state, held and then released
      repeat (3) tick();
      check_hex("rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      check_ctl("rst", 1'b0, 1'b0, 2'b00);
      RESET_N = 1'b1;
      repeat (2) tick();
      check_hex("rst_rel", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      check_ctl("rst_rel", 1'b0, 1'b0, 2'b00);
      $display("txn reset: owner=%0d hex0=%02h", owner, HEX0);

      // 2 + 6: single grant of A, then expiry to idle with the value retained
      data_a = 24'h012345;
      req_a  = 1'b1;
      tick();
      check_ctl("a_grant", 1'b1, 1'b0, 2'b01);
      check_hex("a_grant", HEX5_ZERO, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
      $display("txn grant A data=%06h hex0=%02h", data_a, HEX0);
      req_a  = 1'b0;
      data_a = 24'hFFFFFF;
      tick();
      check_ctl("a_hold1", 1'b0, 1'b0, 2'b01);
      check("a_hold1.hex0", 32'(HEX0), 32'h12);
      repeat (2) tick();
      check_ctl("a_hold3", 1'b0, 1'b0, 2'b01);
      tick();
      check_ctl("a_expire", 1'b0, 1'b0, 2'b00);
      repeat (10) tick();
      check_ctl("a_idle", 1'b0, 1'b0, 2'b00);
      check_hex("a_idle", HEX5_ZERO, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
      $display("txn A expired: owner=%0d hex0=%02h", owner, HEX0);

      // 3: simultaneous requests after reset, A wins the first tie
      do_reset();
      check_hex("rst2", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      data_a = 24'h012345;
      data_b = 24'hABCDEF;
      req_a  = 1'b1;
      req_b  = 1'b1;
      tick();
      check_ctl("tie_a", 1'b1, 1'b0, 2'b01);
      check("tie_a.hex0", 32'(HEX0), 32'h12);
      $display("txn tie grant A");
      req_a = 1'b0;
      for (int c = 1; c < HOLD; c++) begin
         tick();
         check_ctl($sformatf("tie_wait%0d", c), 1'b0, 1'b0, 2'b01);
      end
      tick();
      check_ctl("tie_b", 1'b0, 1'b1, 2'b10);
      check_hex("tie_b", 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E);
      $display("txn grant B data=%06h hex0=%02h", data_b, HEX0);
      req_b = 1'b0;

      // 5: asynchronous reset two cycles into the B grant
      repeat (2) tick();
      check("gntb_mid.owner", 32'(owner), 32'h2);
      RESET_N = 1'b0;
      #1;
      check_hex("async_rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      check_ctl("async_rst", 1'b0, 1'b0, 2'b00);
      repeat (2) tick();
      RESET_N = 1'b1;
      repeat (5) begin
         tick();
         check_ctl("post_rst", 1'b0, 1'b0, 2'b00);
      end
      $display("txn async reset mid-grant: owner=%0d", owner);

      // 4: both requests held, acks alternate every HOLD cycles
      do_reset();
      data_a = 24'h000001;
      data_b = 24'h000002;
      req_a  = 1'b1;
      req_b  = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         check_ctl($sformatf("rr%0d", c),
                   (c % (2*HOLD)) == 0,
                   (c % (2*HOLD)) == HOLD,
                   ((c % (2*HOLD)) < HOLD) ? 2'b01 : 2'b10);
         if (ack_a || ack_b)
            $display("txn rr cycle %0d ack_a=%0d ack_b=%0d hex0=%02h", c, ack_a, ack_b, HEX0);
      end
      check("rr_last.hex0", 32'(HEX0), 32'h79);
      req_a = 1'b0;
      req_b = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
